// File: rtl/femto_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : femto_bus_pkg                                                |
// | Description : Shared transfer-size codes, data-phase FSM states and the    |
// |               byte-lane enable helper for the core's data bus.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package femto_bus_pkg;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte lanes touched by a transfer of the given size at the given word offset.
  // Sizes that cannot be legal return no lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] hsize, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_be_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_be_array                                                |
// | Description : DEPTH x 32 flop array with a byte-enabled write port and an  |
// |               asynchronous read port. Contents are not reset.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sram_be_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  // Each byte lane is its own storage array so every array has a single writer.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    // Commit this lane when the write strobe and its enable are both set.
    always_ff @(posedge clk) begin
      if (we && be[g]) begin
        r_lane[waddr] <= wdata[8*g +: 8];
      end
    end

    assign rdata[8*g +: 8] = r_lane[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/dbus_sram_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dbus_sram_target                                             |
// | Description : Data-bus responder backed by a word-organised local SRAM.    |
// |               Captures address phases, inserts WAIT_CYCLES wait states and |
// |               completes each data phase with hready/hresp/hrdata. Flags    |
// |               misaligned, out-of-range, illegal-size and disallowed        |
// |               instruction-side accesses.                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dbus_sram_target
  import femto_bus_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h2000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter logic        EXEC_EN     = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] haddr,
  input  logic        hprot,
  input  logic [1:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        htrans,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        hready
);

  localparam int         AW          = $clog2(DEPTH);
  localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [AW+1:0]   r_addr;
  logic [1:0]      r_size;
  logic            r_write;
  logic            r_err;
  logic            r_hready;
  logic            r_hresp;

  logic            w_accept;
  logic            w_misalign;
  logic            w_out_of_range;
  logic            w_err;
  logic            w_we;
  logic            w_rd_phase;
  logic [3:0]      w_be;
  logic [31:0]     w_rdata;

  // An address phase is only taken while the bus is free; requests seen during
  // wait states are left for the initiator to hold.
  assign w_accept = htrans & r_hready;

  // Address-phase error decode. BASE is aligned to the array size, so range
  // membership is just a compare of the bits above the array index.
  always_comb begin
    w_misalign     = ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    w_out_of_range = (haddr[31:AW+2] != BASE[31:AW+2]);
    w_err          = (hsize == 2'd3) || w_misalign || w_out_of_range ||
                     (!hprot && !EXEC_EN);
  end

  // Data-phase FSM: captures the address phase, counts wait states and
  // registers hready/hresp for the cycle the phase completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_size   <= 2'd0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_addr  <= haddr[AW+1:0];
            r_size  <= hsize;
            r_write <= hwrite;
            r_err   <= w_err;
            if (WAIT_CYCLES == 0) begin
              r_state  <= RESP;
              r_hready <= 1'b1;
              r_hresp  <= w_err;
            end else begin
              r_state  <= WAIT;
              r_cnt    <= C_WAIT_LOAD;
              r_hready <= 1'b0;
              r_hresp  <= 1'b0;
            end
          end else begin
            r_state  <= IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= RESP;
            r_hready <= 1'b1;
            r_hresp  <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_hready <= 1'b1;
          r_hresp  <= 1'b0;
        end
      endcase
    end
  end

  // Writes land at the end of the completing cycle, so a read accepted in that
  // same cycle sees the new word in its own (later) data phase.
  assign w_we       = (r_state == RESP) && r_write && !r_err;
  assign w_rd_phase = (r_state == RESP) && !r_write && !r_err;
  assign w_be       = byte_en(r_size, r_addr[1:0]);

  sram_be_array #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (w_we),
    .be    (w_be),
    .waddr (r_addr[AW+1:2]),
    .wdata (hwdata),
    .raddr (r_addr[AW+1:2]),
    .rdata (w_rdata)
  );

  assign hready = r_hready;
  assign hresp  = r_hresp;
  assign hrdata = w_rd_phase ? w_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dbus_sram_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dbus_sram_target                                          |
// | Description : Self-checking bench for dbus_sram_target: a zero-wait and a  |
// |               three-wait instance, vector table, corner sequences and a    |
// |               randomized run against a word-array reference model.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dbus_sram_target;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 256;
  localparam logic [31:0] LIMIT = BASE + 32'(DEPTH * 4);

  logic        clk;
  logic        rstn;
  logic [31:0] haddr;
  logic        hprot;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        htrans;
  logic        sel;

  logic        htrans0, htrans1;
  logic [31:0] hrdata0, hrdata1, hrdata;
  logic        hresp0, hresp1, hresp;
  logic        hready0, hready1, hready;

  int n_checks;
  int n_errors;

  logic [31:0] mdl [2][DEPTH];

  assign htrans0 = htrans & (sel == 1'b0);
  assign htrans1 = htrans & (sel == 1'b1);
  assign hrdata  = sel ? hrdata1 : hrdata0;
  assign hresp   = sel ? hresp1  : hresp0;
  assign hready  = sel ? hready1 : hready0;

  dbus_sram_target #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0), .EXEC_EN(1'b0)) u_dut0 (
    .clk(clk), .rstn(rstn), .haddr(haddr), .hprot(hprot), .hsize(hsize), .hwrite(hwrite),
    .hwdata(hwdata), .htrans(htrans0), .hrdata(hrdata0), .hresp(hresp0), .hready(hready0));

  dbus_sram_target #(.BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3), .EXEC_EN(1'b0)) u_dut1 (
    .clk(clk), .rstn(rstn), .haddr(haddr), .hprot(hprot), .hsize(hsize), .hwrite(hwrite),
    .hwdata(hwdata), .htrans(htrans1), .hrdata(hrdata1), .hresp(hresp1), .hready(hready1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: applies the bus rules to a plain word array.
  task automatic model_apply(input int s, input logic [31:0] a, input logic [1:0] sz,
                             input logic wr, input logic pr, input logic [31:0] wd,
                             output logic [31:0] er, output logic ersp);
    logic err;
    int   idx, lo, hi;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
          (a < BASE) || (a >= LIMIT) || !pr;
    er   = 32'h0;
    ersp = err;
    if (!err) begin
      idx = int'((a - BASE) >> 2);
      if (wr) begin
        if (sz == 2'd0)      begin lo = int'(a[1:0]);   hi = lo;     end
        else if (sz == 2'd1) begin lo = a[1] ? 2 : 0;   hi = lo + 1; end
        else                 begin lo = 0;              hi = 3;      end
        for (int b = lo; b <= hi; b++) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        er = mdl[s][idx];
      end
    end
  endtask

  // One isolated transfer; entered and left one time unit after a rising edge.
  task automatic txn(input logic [31:0] a, input logic [1:0] sz, input logic wr, input logic pr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                     output int nw);
    haddr = a; hsize = sz; hwrite = wr; hprot = pr; htrans = 1'b1;
    @(posedge clk); #1;
    htrans = 1'b0; hwdata = wd;
    nw = 0;
    while (!hready && nw < 40) begin
      @(posedge clk); #1;
      nw++;
    end
    rd  = hrdata;
    rsp = hresp;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic        prot;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_rsp;
  } vec_t;

  vec_t vt [18];

  initial begin
    logic [31:0] rd, er, a, wd;
    logic        rsp, ersp, wr, pr;
    logic [1:0]  sz;
    int          nw, k;

    n_checks = 0; n_errors = 0;

    vt[0]  = '{BASE + 0,   2'd2, 1'b1, 1'b1, 32'h0000_0000, 32'h0, 1'b0};
    vt[1]  = '{BASE + 3,   2'd0, 1'b1, 1'b1, 32'hA500_0000, 32'h0, 1'b0};
    vt[2]  = '{BASE + 0,   2'd1, 1'b1, 1'b1, 32'h0000_1234, 32'h0, 1'b0};
    vt[3]  = '{BASE + 0,   2'd2, 1'b0, 1'b1, 32'h0,         32'hA500_1234, 1'b0};
    vt[4]  = '{BASE + 8,   2'd2, 1'b1, 1'b1, 32'h1122_3344, 32'h0, 1'b0};
    vt[5]  = '{BASE + 10,  2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vt[6]  = '{BASE + 8,   2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vt[7]  = '{LIMIT,      2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vt[8]  = '{BASE + 8,   2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vt[9]  = '{BASE + 9,   2'd1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vt[10] = '{BASE + 8,   2'd2, 1'b0, 1'b1, 32'h0,         32'h1122_3344, 1'b0};
    vt[11] = '{BASE + 8,   2'd2, 1'b0, 1'b0, 32'h0,         32'h0, 1'b1};
    vt[12] = '{BASE + 10,  2'd1, 1'b0, 1'b1, 32'h0,         32'h1122_3344, 1'b0};
    vt[13] = '{BASE + 9,   2'd0, 1'b1, 1'b1, 32'h0000_EE00, 32'h0, 1'b0};
    vt[14] = '{BASE + 8,   2'd2, 1'b0, 1'b1, 32'h0,         32'h1122_EE44, 1'b0};
    vt[15] = '{BASE + 10,  2'd1, 1'b1, 1'b1, 32'hABCD_0000, 32'h0, 1'b0};
    vt[16] = '{BASE + 8,   2'd2, 1'b0, 1'b1, 32'h0,         32'hABCD_EE44, 1'b0};
    vt[17] = '{BASE - 4,   2'd2, 1'b0, 1'b1, 32'h0,         32'h0, 1'b1};

    // Reset with a request on the bus.
    sel = 1'b0; rstn = 1'b0;
    haddr = BASE; hsize = 2'd2; hwrite = 1'b1; hprot = 1'b1; hwdata = 32'hFFFF_FFFF; htrans = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready0", {31'b0, hready0}, 32'h1);
    chk("rst_hresp0",  {31'b0, hresp0},  32'h0);
    chk("rst_hrdata0", hrdata0,          32'h0);
    chk("rst_hready1", {31'b0, hready1}, 32'h1);
    chk("rst_hresp1",  {31'b0, hresp1},  32'h0);
    chk("rst_hrdata1", hrdata1,          32'h0);
    htrans = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;

    // Seed the low words of both arrays so reads have known contents.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        model_apply(s, BASE + 32'(4 * i), 2'd2, 1'b1, 1'b1, wd, er, ersp);
        txn(BASE + 32'(4 * i), 2'd2, 1'b1, 1'b1, wd, rd, rsp, nw);
        chk("init_resp", {31'b0, rsp}, 32'h0);
      end
    end

    // Vector table on the zero-wait instance.
    sel = 1'b0;
    for (int i = 0; i < 18; i++) begin
      model_apply(0, vt[i].addr, vt[i].size, vt[i].wr, vt[i].prot, vt[i].wdata, er, ersp);
      txn(vt[i].addr, vt[i].size, vt[i].wr, vt[i].prot, vt[i].wdata, rd, rsp, nw);
      chk($sformatf("vec%0d_resp", i),  {31'b0, rsp}, {31'b0, vt[i].exp_rsp});
      chk($sformatf("vec%0d_rdata", i), rd,           vt[i].exp_rd);
      chk($sformatf("vec%0d_waits", i), 32'(nw),      32'h0);
    end

    // Back-to-back write then read of the same word, no bubble.
    haddr = BASE + 4; hsize = 2'd2; hwrite = 1'b1; hprot = 1'b1; htrans = 1'b1;
    @(posedge clk); #1;
    chk("b2b_wr_hready", {31'b0, hready}, 32'h1);
    hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
    @(posedge clk); #1;
    htrans = 1'b0;
    chk("b2b_rd_hready", {31'b0, hready}, 32'h1);
    chk("b2b_rd_hrdata", hrdata,          32'hDEAD_BEEF);
    chk("b2b_rd_hresp",  {31'b0, hresp},  32'h0);
    mdl[0][1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("b2b_idle_hready", {31'b0, hready}, 32'h1);

    // Three-wait instance: request held during waits is taken only on completion.
    sel = 1'b1;
    haddr = BASE + 4; hsize = 2'd2; hwrite = 1'b0; hprot = 1'b1; htrans = 1'b1;
    @(posedge clk); #1;
    haddr = BASE + 8;
    nw = 0;
    while (!hready && nw < 40) begin @(posedge clk); #1; nw++; end
    chk("hold_a_waits", 32'(nw), 32'd3);
    chk("hold_a_rdata", hrdata,  mdl[1][1]);
    @(posedge clk); #1;
    htrans = 1'b0;
    chk("hold_b_busy", {31'b0, hready}, 32'h0);
    nw = 0;
    while (!hready && nw < 40) begin @(posedge clk); #1; nw++; end
    chk("hold_b_waits", 32'(nw), 32'd3);
    chk("hold_b_rdata", hrdata,  mdl[1][2]);
    @(posedge clk); #1;

    // Reset arriving during the wait states of a write drops the write.
    haddr = BASE + 12; hsize = 2'd2; hwrite = 1'b1; hprot = 1'b1; htrans = 1'b1;
    @(posedge clk); #1;
    htrans = 1'b0; hwdata = 32'h55AA_55AA;
    chk("rstw_busy", {31'b0, hready}, 32'h0);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rstw_hready", {31'b0, hready}, 32'h1);
    chk("rstw_hresp",  {31'b0, hresp},  32'h0);
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    @(posedge clk); #1;
    txn(BASE + 12, 2'd2, 1'b0, 1'b1, 32'h0, rd, rsp, nw);
    chk("rstw_readback", rd, mdl[1][3]);

    // Requests presented while in reset never reach the array.
    sel = 1'b0; rstn = 1'b0;
    haddr = BASE + 20; hsize = 2'd2; hwrite = 1'b1; hprot = 1'b1;
    hwdata = 32'hCAFE_F00D; htrans = 1'b1;
    repeat (3) @(posedge clk);
    #1; htrans = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;
    txn(BASE + 20, 2'd2, 1'b0, 1'b1, 32'h0, rd, rsp, nw);
    chk("rsth_readback", rd, mdl[0][5]);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 240; i++) begin
      sel = (i % 4 == 3);
      k = int'($urandom_range(0, 9));
      if (k == 0)      a = LIMIT + $urandom_range(0, 15);
      else if (k == 1) a = BASE - 32'd1 - $urandom_range(0, 15);
      else             a = BASE + $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      pr = ($urandom_range(0, 7) != 0);
      wd = $urandom;
      model_apply(sel ? 1 : 0, a, sz, wr, pr, wd, er, ersp);
      txn(a, sz, wr, pr, wd, rd, rsp, nw);
      chk($sformatf("rnd%0d_resp", i),  {31'b0, rsp}, {31'b0, ersp});
      chk($sformatf("rnd%0d_rdata", i), rd,           er);
      chk($sformatf("rnd%0d_waits", i), 32'(nw),      sel ? 32'd3 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
